bird_motion_ctrl: RTL

Game-logic core between the PS2 key-event interface and the game render controller. It consumes space-key press and release events with an ack handshake and runs a gravity/flap physics model on a frame tick. It produces bird vertical position, score, game state and debug LEDs. Replaces the fixed ±10-pixel bounce test logic with a parametrised, stateful model.

---
 rtl/bird_pkg.sv | 19 +
 rtl/bird_tick_gen.sv | 26 ++
 rtl/bird_motion_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/bird_pkg.sv
// Shared codes for the bird game-logic core: game state, key event and LED bit positions.
package bird_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } game_state_e;

  typedef enum logic [1:0] {
    KEY_NONE    = 2'd0,
    KEY_PRESS   = 2'd1,
    KEY_RELEASE = 2'd2
  } key_code_e;

  localparam int LED_FLAP = 0;
  localparam int LED_DEAD = 1;

endpackage

// File: rtl/bird_tick_gen.sv
// Free-running frame-tick divider: one-cycle tick every TICK_DIV clocks, cleared only by reset.
module bird_tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (tick) cnt_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bird_motion_ctrl.sv
// Bird game-logic core: key-event handshake, game FSM and gravity/flap physics on a frame tick.
// Optional build macro BIRD_BOUNCE_MODE_EN replaces physics with fixed-step bounce movement.
//
// state   | meaning
// IDLE    | bird parked at Y_START, waiting for a press to start
// RUN     | physics (or bounce steps) active, presses flap and score
// DEAD    | bird hit the floor, everything frozen until a press resets to IDLE
module bird_motion_ctrl
  import bird_pkg::*;
#(
  parameter int Y_WIDTH     = 10,
  parameter int Y_MAX       = 456,
  parameter int Y_START     = 228,
  parameter int SCORE_WIDTH = 16,
  parameter int GRAVITY     = 1,
  parameter int FLAP_VEL    = 8,
  parameter int VEL_MAX     = 12,
  parameter int TICK_DIV    = 833333,
  parameter int STEP        = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             key_state,
  output logic                   key_ack,
  output logic [Y_WIDTH-1:0]     bird_y,
  output logic [SCORE_WIDTH-1:0] score,
  output logic [1:0]             game_state,
  output logic [7:0]             leds
);

  localparam int NW = Y_WIDTH + 2;
  localparam logic signed [Y_WIDTH:0] VEL_FLAP = (Y_WIDTH+1)'(-FLAP_VEL);
  localparam logic signed [Y_WIDTH:0] VEL_CAP  = (Y_WIDTH+1)'(VEL_MAX);
  localparam logic signed [Y_WIDTH:0] VEL_G    = (Y_WIDTH+1)'(GRAVITY);
  localparam logic signed [NW-1:0]    Y_MAX_S  = NW'(Y_MAX);
  localparam logic signed [NW-1:0]    ZERO_S   = '0;
  localparam logic [Y_WIDTH-1:0]      Y_MAX_U  = Y_WIDTH'(Y_MAX);
  localparam logic [Y_WIDTH-1:0]      Y_START_U = Y_WIDTH'(Y_START);
  localparam logic [Y_WIDTH-1:0]      STEP_U   = Y_WIDTH'(STEP);

  if (TICK_DIV < 2 || STEP < 1 || STEP > Y_MAX) begin : g_bad_param
    $error("bird_motion_ctrl: TICK_DIV must be >= 2 and STEP within 1..Y_MAX");
  end

  game_state_e              state_q, state_d;
  logic [Y_WIDTH-1:0]       y_q, y_d;
  logic signed [Y_WIDTH:0]  vel_q, vel_d, vel_t;
  logic signed [NW-1:0]     next_y;
  logic [SCORE_WIDTH-1:0]   score_q, score_d;
  logic                     ack_q, ack_d;
  logic                     led_q, led_d;
  logic                     tick, accept, press, release_ev;
`ifdef BIRD_BOUNCE_MODE_EN
  logic                     dir_q, dir_d;
`endif

  bird_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  // While the ack is high the input level is ignored, so a held key is seen once per ack.
  assign accept     = !ack_q && (key_state == KEY_PRESS || key_state == KEY_RELEASE);
  assign press      = accept && (key_state == KEY_PRESS);
  assign release_ev = accept && (key_state == KEY_RELEASE);

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    score_d = score_q;
    led_d   = led_q;
    ack_d   = accept;
    vel_t   = '0;
    next_y  = '0;
`ifdef BIRD_BOUNCE_MODE_EN
    dir_d   = dir_q;
`endif
    if (press)           led_d = 1'b1;
    else if (release_ev) led_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (press) begin
          state_d = ST_RUN;
          vel_d   = VEL_FLAP;
        end
      end
      ST_RUN: begin
`ifdef BIRD_BOUNCE_MODE_EN
        if (press) begin
          dir_d = dir_q ^ (y_q == '0 || y_q >= Y_MAX_U);
          if (!dir_d) y_d = (y_q >= STEP_U) ? y_q - STEP_U : '0;
          else        y_d = (y_q >= Y_MAX_U - STEP_U) ? Y_MAX_U : y_q + STEP_U;
          score_d = (&score_q) ? score_q : score_q + 1'b1;
        end
`else
        if (press) begin
          vel_d   = VEL_FLAP;
          score_d = (&score_q) ? score_q : score_q + 1'b1;
        end
        // Flap lands first so a same-cycle tick integrates from the fresh flap velocity.
        if (tick) begin
          vel_t = vel_d + VEL_G;
          if (vel_t > VEL_CAP) vel_t = VEL_CAP;
          vel_d  = vel_t;
          next_y = $signed({2'b00, y_q}) + NW'(vel_t);
          if (next_y <= ZERO_S) begin
            y_d = '0;
          end else if (next_y >= Y_MAX_S) begin
            y_d     = Y_MAX_U;
            state_d = ST_DEAD;
          end else begin
            y_d = next_y[Y_WIDTH-1:0];
          end
        end
`endif
      end
      ST_DEAD: begin
        if (press) begin
          state_d = ST_IDLE;
          y_d     = Y_START_U;
          vel_d   = '0;
          score_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      y_q     <= Y_START_U;
      vel_q   <= '0;
      score_q <= '0;
      ack_q   <= 1'b0;
      led_q   <= 1'b0;
`ifdef BIRD_BOUNCE_MODE_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      score_q <= score_d;
      ack_q   <= ack_d;
      led_q   <= led_d;
`ifdef BIRD_BOUNCE_MODE_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign key_ack    = ack_q;
  assign bird_y     = y_q;
  assign score      = score_q;
  assign game_state = state_q;
  always_comb begin
    leds           = '0;
    leds[LED_FLAP] = led_q;
    leds[LED_DEAD] = (state_q == ST_DEAD);
  end

endmodule
